// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI4 subordinate serving one burst at a time from a single-port SRAM.
// Define AXI_SRAM_RESPONDER_EXCL_EN to add a single-reservation exclusive-access monitor.
package ariane_axi;
   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [5:0]  atop;
   } aw_chan_t;
   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
   } w_chan_t;
   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
   } ar_chan_t;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;
   typedef struct packed {
      logic [3:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;
   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;
   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;
endpackage

module axi_sram_responder #(
   parameter int unsigned AxiAddrWidth = 64,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned AxiIdWidth   = 4,
   parameter int unsigned MemAddrWidth = 14,
   parameter type axi_req_t = ariane_axi::req_t,
   parameter type axi_rsp_t = ariane_axi::resp_t
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  axi_req_t                  axi_req_i,
   output axi_rsp_t                  axi_resp_o,
   output logic                      mem_req_o,
   output logic                      mem_we_o,
   output logic [MemAddrWidth-1:0]   mem_addr_o,
   output logic [AxiDataWidth-1:0]   mem_wdata_o,
   output logic [AxiDataWidth/8-1:0] mem_be_o,
   input  logic [AxiDataWidth-1:0]   mem_rdata_i
);
   localparam int unsigned OffW = $clog2(AxiDataWidth/8);
   localparam int unsigned WinW = MemAddrWidth + OffW;
   localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP} state_e;

   state_e                    state_q, state_d;
   logic [AxiIdWidth-1:0]     id_q;
   logic [AxiAddrWidth-1:0]   addr_q, addr_nxt;
   logic [7:0]                len_q, beat_q;
   logic [2:0]                size_q;
   logic [1:0]                burst_q, b_resp_q, r_resp_q;
   logic                      dec_q, slv_q, drain_q, rr_q;
   logic                      r_valid_q, r_last_q, b_valid_q;
   logic [AxiDataWidth-1:0]   r_data_q;
   logic                      grant_ar, ar_hs, aw_hs, w_hs, r_hs, b_hs;
   logic                      in_win, wr_en, dec_n, slv_n, drain_n;
   logic                      excl_q, sc_fail;
   logic                      unused_lock;

   function automatic logic [AxiAddrWidth-1:0] next_addr(input logic [AxiAddrWidth-1:0] a,
                                                         input logic [2:0] size,
                                                         input logic [7:0] len,
                                                         input logic [1:0] burst);
      logic [AxiAddrWidth-1:0] step, incr, wmask;
      step  = AxiAddrWidth'(1) << size;
      incr  = (a & ~(step - AxiAddrWidth'(1))) + step;
      wmask = ((AxiAddrWidth'(len) + AxiAddrWidth'(1)) << size) - AxiAddrWidth'(1);
      return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~wmask) | (incr & wmask) : incr;
   endfunction

   assign addr_nxt = next_addr(addr_q, size_q, len_q, burst_q);
   assign in_win   = ~|addr_q[AxiAddrWidth-1:WinW];
   // RR pointer set means AW is favoured when both address channels are valid
   assign grant_ar = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !rr_q);
   assign ar_hs    = state_q == IDLE && grant_ar;
   assign aw_hs    = state_q == IDLE && axi_req_i.aw_valid && !grant_ar;
   assign w_hs     = state_q == WR_DATA && axi_req_i.w_valid;
   assign r_hs     = state_q == RD_RESP && axi_req_i.r_ready;
   assign b_hs     = state_q == WR_RESP && axi_req_i.b_ready;
   assign wr_en    = w_hs && !drain_q && in_win;
   // Beats past len (and atop/failed-exclusive bursts) drain without touching SRAM
   assign dec_n    = dec_q | (!drain_q && !in_win);
   assign slv_n    = slv_q | (!drain_q && (axi_req_i.w.last ? beat_q < len_q : beat_q == len_q));
   assign drain_n  = drain_q | (!axi_req_i.w.last && beat_q == len_q);
   assign unused_lock = ^{axi_req_i.ar.lock, axi_req_i.aw.lock};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = ar_hs ? RD_ISSUE : aw_hs ? WR_DATA : IDLE;
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT:  state_d = RD_RESP;
         RD_RESP:  state_d = r_hs ? (r_last_q ? IDLE : RD_ISSUE) : RD_RESP;
         WR_DATA:  state_d = w_hs && axi_req_i.w.last ? WR_RESP : WR_DATA;
         WR_RESP:  state_d = b_hs ? IDLE : WR_RESP;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      axi_resp_o          = '0;
      axi_resp_o.ar_ready = ar_hs;
      axi_resp_o.aw_ready = aw_hs;
      axi_resp_o.w_ready  = state_q == WR_DATA;
      axi_resp_o.b_valid  = b_valid_q;
      axi_resp_o.b.id     = id_q;
      axi_resp_o.b.resp   = b_resp_q;
      axi_resp_o.r_valid  = r_valid_q;
      axi_resp_o.r.id     = id_q;
      axi_resp_o.r.data   = r_data_q;
      axi_resp_o.r.resp   = r_resp_q;
      axi_resp_o.r.last   = r_last_q;
      mem_req_o           = (state_q == RD_ISSUE && in_win) || wr_en;
      mem_we_o            = state_q == WR_DATA;
      mem_addr_o          = addr_q[WinW-1:OffW];
      mem_wdata_o         = axi_req_i.w.data;
      mem_be_o            = axi_req_i.w.strb;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         beat_q    <= '0;
         dec_q     <= 1'b0;
         slv_q     <= 1'b0;
         drain_q   <= 1'b0;
         rr_q      <= 1'b0;
         r_valid_q <= 1'b0;
         r_last_q  <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= OKAY;
         b_valid_q <= 1'b0;
         b_resp_q  <= OKAY;
      end else begin
         if (ar_hs) begin
            id_q    <= axi_req_i.ar.id;
            addr_q  <= axi_req_i.ar.addr;
            len_q   <= axi_req_i.ar.len;
            size_q  <= axi_req_i.ar.size;
            burst_q <= axi_req_i.ar.burst;
            beat_q  <= '0;
            dec_q   <= 1'b0;
            slv_q   <= 1'b0;
            drain_q <= 1'b0;
            rr_q    <= 1'b1;
         end
         if (aw_hs) begin
            id_q    <= axi_req_i.aw.id;
            addr_q  <= axi_req_i.aw.addr;
            len_q   <= axi_req_i.aw.len;
            size_q  <= axi_req_i.aw.size;
            burst_q <= axi_req_i.aw.burst;
            beat_q  <= '0;
            dec_q   <= 1'b0;
            slv_q   <= |axi_req_i.aw.atop;
            drain_q <= |axi_req_i.aw.atop | sc_fail;
            rr_q    <= 1'b0;
         end
         if (state_q == RD_WAIT) begin
            r_valid_q <= 1'b1;
            r_data_q  <= in_win ? mem_rdata_i : '0;
            r_resp_q  <= !in_win ? DECERR : excl_q ? EXOKAY : OKAY;
            r_last_q  <= beat_q == len_q;
         end
         if (r_hs) begin
            r_valid_q <= 1'b0;
            beat_q    <= beat_q + 8'd1;
            addr_q    <= addr_nxt;
         end
         if (w_hs) begin
            beat_q  <= beat_q + 8'd1;
            addr_q  <= addr_nxt;
            dec_q   <= dec_n;
            slv_q   <= slv_n;
            drain_q <= drain_n;
            if (axi_req_i.w.last) begin
               b_valid_q <= 1'b1;
               b_resp_q  <= dec_n ? DECERR : slv_n ? SLVERR : excl_q ? EXOKAY : OKAY;
            end
         end
         if (b_hs) b_valid_q <= 1'b0;
      end
   end

`ifdef AXI_SRAM_RESPONDER_EXCL_EN
   logic                    res_valid_q, sc_match;
   logic [AxiIdWidth-1:0]   res_id_q;
   logic [AxiAddrWidth-1:0] res_addr_q;

   assign sc_match = res_valid_q && res_id_q == axi_req_i.aw.id && res_addr_q == axi_req_i.aw.addr;
   assign sc_fail  = axi_req_i.aw.lock && !sc_match;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_addr_q  <= '0;
         excl_q      <= 1'b0;
      end else begin
         if (ar_hs) begin
            excl_q <= axi_req_i.ar.lock;
            if (axi_req_i.ar.lock) begin
               res_valid_q <= 1'b1;
               res_id_q    <= axi_req_i.ar.id;
               res_addr_q  <= axi_req_i.ar.addr;
            end
         end
         if (aw_hs) begin
            excl_q <= axi_req_i.aw.lock && sc_match;
            if (axi_req_i.aw.lock && sc_match) res_valid_q <= 1'b0;
         end
         // Any plain store to the reserved word breaks the reservation
         if (wr_en && !excl_q && addr_q[AxiAddrWidth-1:OffW] == res_addr_q[AxiAddrWidth-1:OffW])
            res_valid_q <= 1'b0;
      end
   end
`else
   assign excl_q  = 1'b0;
   assign sc_fail = 1'b0;
`endif
endmodule

// File: tb/tb_axi_sram_responder.sv
// tb_axi_sram_responder: directed bench for axi_sram_responder with a behavioural SRAM.
module tb_axi_sram_responder;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   ariane_axi::req_t  req;
   ariane_axi::resp_t rsp;
   logic        mem_req, mem_we;
   logic [13:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata, merge;
   logic [7:0]  mem_be;
   logic [63:0] sram [0:16383];
   int checks = 0, failures = 0, wr_cnt = 0, rd_cnt = 0;
   logic [63:0] wd [4] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                           64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};

   always #5 clk_i = ~clk_i;

   axi_sram_responder dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .axi_req_i(req), .axi_resp_o(rsp),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
   );

   always @(posedge clk_i) begin
      if (mem_req) begin
         if (mem_we) begin
            merge = sram[mem_addr];
            for (int b = 0; b < 8; b++) if (mem_be[b]) merge[8*b +: 8] = mem_wdata[8*b +: 8];
            sram[mem_addr] <= merge;
            wr_cnt <= wr_cnt + 1;
         end else begin
            mem_rdata <= sram[mem_addr];
            rd_cnt <= rd_cnt + 1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_ar(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic lock);
      req.ar.id = id; req.ar.addr = a; req.ar.len = len;
      req.ar.size = 3'd3; req.ar.burst = burst; req.ar.lock = lock;
   endtask

   task automatic set_aw(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic lock, input logic [5:0] atop);
      req.aw.id = id; req.aw.addr = a; req.aw.len = len;
      req.aw.size = 3'd3; req.aw.burst = 2'b01; req.aw.lock = lock; req.aw.atop = atop;
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                          input logic [1:0] burst, input logic lock);
      int n;
      @(negedge clk_i);
      set_ar(id, a, len, burst, lock);
      req.ar_valid = 1'b1;
      n = 0;
      #1;
      while (!rsp.ar_ready && n < 50) begin @(negedge clk_i); #1; n++; end
      chk("ar_handshake", 64'(rsp.ar_ready), 64'd1);
      @(posedge clk_i);
      #1 req.ar_valid = 1'b0;
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                          input logic lock, input logic [5:0] atop);
      int n;
      @(negedge clk_i);
      set_aw(id, a, len, lock, atop);
      req.aw_valid = 1'b1;
      n = 0;
      #1;
      while (!rsp.aw_ready && n < 50) begin @(negedge clk_i); #1; n++; end
      chk("aw_handshake", 64'(rsp.aw_ready), 64'd1);
      @(posedge clk_i);
      #1 req.aw_valid = 1'b0;
   endtask

   task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int n;
      @(negedge clk_i);
      req.w.data = data; req.w.strb = strb; req.w.last = last;
      req.w_valid = 1'b1;
      n = 0;
      #1;
      while (!rsp.w_ready && n < 50) begin @(negedge clk_i); #1; n++; end
      chk("w_handshake", 64'(rsp.w_ready), 64'd1);
      @(posedge clk_i);
      #1 req.w_valid = 1'b0;
   endtask

   task automatic r_get(output logic [63:0] d, output logic [3:0] id, output logic [1:0] rs,
                        output logic last, output int lat);
      lat = 0;
      while (!rsp.r_valid && lat < 100) begin @(negedge clk_i); lat++; end
      chk("r_valid_seen", 64'(rsp.r_valid), 64'd1);
      d = rsp.r.data; id = rsp.r.id; rs = rsp.r.resp; last = rsp.r.last;
      req.r_ready = 1'b1;
      @(posedge clk_i);
      #1 req.r_ready = 1'b0;
   endtask

   task automatic b_get(output logic [3:0] id, output logic [1:0] rs);
      int n;
      n = 0;
      while (!rsp.b_valid && n < 100) begin @(negedge clk_i); n++; end
      chk("b_valid_seen", 64'(rsp.b_valid), 64'd1);
      id = rsp.b.id; rs = rsp.b.resp;
      req.b_ready = 1'b1;
      @(posedge clk_i);
      #1 req.b_ready = 1'b0;
   endtask

   logic [63:0] d, d0;
   logic [3:0]  id;
   logic [1:0]  rs;
   logic        l, ok;
   int          lat, c0, n;
   logic [63:0] wrap_exp [4] = '{64'hA3, 64'hA0, 64'hA1, 64'hA2};

   initial begin
      req = '0;
      for (int i = 0; i < 4; i++) sram[i] = 64'hA0 + 64'(i);
      sram[14'h10] = 64'hDEAD_BEEF_0123_4567;
      #3;
      chk("reset_outputs", 64'({rsp.ar_ready, rsp.aw_ready, rsp.w_ready, rsp.r_valid, rsp.b_valid, mem_req}), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // single read
      c0 = rd_cnt;
      ar_send(4'b1100, 64'h80, 8'd0, 2'b01, 1'b0);
      r_get(d, id, rs, l, lat);
      chk("rd1_latency", 64'(lat), 64'd3);
      chk("rd1_data", d, 64'hDEAD_BEEF_0123_4567);
      chk("rd1_id", 64'(id), 64'hC);
      chk("rd1_last", 64'(l), 64'd1);
      chk("rd1_resp", 64'(rs), 64'd0);
      chk("rd1_sram_reads", 64'(rd_cnt - c0), 64'd1);

      // INCR write burst and readback
      c0 = wr_cnt;
      aw_send(4'b1000, 64'h100, 8'd3, 1'b0, 6'd0);
      for (int i = 0; i < 4; i++) w_send(wd[i], 8'hFF, i == 3);
      b_get(id, rs);
      chk("wr_b_id", 64'(id), 64'h8);
      chk("wr_b_resp", 64'(rs), 64'd0);
      chk("wr_sram_writes", 64'(wr_cnt - c0), 64'd4);
      for (int i = 0; i < 4; i++) chk("wr_sram_word", sram[14'h20 + 14'(i)], wd[i]);
      ar_send(4'b0010, 64'h100, 8'd3, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) begin
         r_get(d, id, rs, l, lat);
         chk("rb_data", d, wd[i]);
         chk("rb_last", 64'(l), 64'(i == 3));
      end

      // partial strobe write
      aw_send(4'b0001, 64'h108, 8'd0, 1'b0, 6'd0);
      w_send(64'h0, 8'h0F, 1'b1);
      b_get(id, rs);
      ar_send(4'b0001, 64'h108, 8'd0, 2'b01, 1'b0);
      r_get(d, id, rs, l, lat);
      chk("strb_merge", d, 64'h5555_6666_0000_0000);

      // WRAP read
      ar_send(4'b0011, 64'h18, 8'd3, 2'b10, 1'b0);
      for (int i = 0; i < 4; i++) begin
         r_get(d, id, rs, l, lat);
         chk("wrap_data", d, wrap_exp[i]);
         chk("wrap_last", 64'(l), 64'(i == 3));
         if (i == 1) chk("wrap_beat_latency", 64'(lat), 64'd3);
      end

      // last served was a read: AW wins a tie
      @(negedge clk_i);
      set_ar(4'd3, 64'h180, 8'd0, 2'b01, 1'b0);
      set_aw(4'd5, 64'h180, 8'd0, 1'b0, 6'd0);
      req.ar_valid = 1'b1; req.aw_valid = 1'b1;
      #1 chk("arb_aw_first", 64'({rsp.ar_ready, rsp.aw_ready}), 64'b01);
      @(posedge clk_i);
      #1 begin req.ar_valid = 1'b0; req.aw_valid = 1'b0; end
      w_send(64'hC0FFEE, 8'hFF, 1'b1);
      b_get(id, rs);
      chk("arb_b_id", 64'(id), 64'd5);

      // last served was a write: AR wins, R held under back-pressure, AW waits
      @(negedge clk_i);
      set_aw(4'd6, 64'h188, 8'd0, 1'b0, 6'd0);
      req.ar_valid = 1'b1; req.aw_valid = 1'b1;
      #1 chk("arb_ar_first", 64'({rsp.ar_ready, rsp.aw_ready}), 64'b10);
      @(posedge clk_i);
      #1 req.ar_valid = 1'b0;
      n = 0;
      while (!rsp.r_valid && n < 20) begin @(negedge clk_i); n++; end
      d0 = rsp.r.data;
      ok = rsp.r_valid;
      repeat (5) begin
         @(negedge clk_i);
         if (rsp.r.data !== d0 || !rsp.r_valid || rsp.aw_ready) ok = 1'b0;
      end
      chk("r_hold_stable", 64'(ok), 64'd1);
      r_get(d, id, rs, l, lat);
      chk("r_hold_data", d, 64'hC0FFEE);
      chk("r_hold_id", 64'(id), 64'd3);
      n = 0;
      #1;
      while (!rsp.aw_ready && n < 20) begin @(negedge clk_i); #1; n++; end
      chk("aw_after_r", 64'(rsp.aw_ready), 64'd1);
      @(posedge clk_i);
      #1 req.aw_valid = 1'b0;
      w_send(64'hBEEF, 8'hFF, 1'b1);
      b_get(id, rs);
      chk("aw_after_r_b_id", 64'(id), 64'd6);

      // decode error on read
      c0 = rd_cnt;
      ar_send(4'd7, 64'h20000, 8'd0, 2'b01, 1'b0);
      r_get(d, id, rs, l, lat);
      chk("rd_decerr_resp", 64'(rs), 64'd3);
      chk("rd_decerr_data", d, 64'd0);
      chk("rd_decerr_no_req", 64'(rd_cnt - c0), 64'd0);

      // early w.last
      c0 = wr_cnt;
      aw_send(4'd9, 64'h200, 8'd3, 1'b0, 6'd0);
      w_send(64'h1, 8'hFF, 1'b0);
      w_send(64'h2, 8'hFF, 1'b1);
      b_get(id, rs);
      chk("early_last_resp", 64'(rs), 64'd2);
      chk("early_last_id", 64'(id), 64'd9);
      chk("early_last_writes", 64'(wr_cnt - c0), 64'd2);

      // missing w.last at beat len
      c0 = wr_cnt;
      aw_send(4'd10, 64'h300, 8'd0, 1'b0, 6'd0);
      w_send(64'h77, 8'hFF, 1'b0);
      w_send(64'h88, 8'hFF, 1'b1);
      b_get(id, rs);
      chk("overrun_resp", 64'(rs), 64'd2);
      chk("overrun_writes", 64'(wr_cnt - c0), 64'd1);
      chk("overrun_word", sram[14'h60], 64'h77);

      // atop unsupported
      c0 = wr_cnt;
      aw_send(4'd11, 64'h300, 8'd0, 1'b0, 6'h20);
      w_send(64'h99, 8'hFF, 1'b1);
      b_get(id, rs);
      chk("atop_resp", 64'(rs), 64'd2);
      chk("atop_no_write", 64'(wr_cnt - c0), 64'd0);

      // write burst crossing the window end
      c0 = wr_cnt;
      aw_send(4'd12, 64'h1FFF8, 8'd1, 1'b0, 6'd0);
      w_send(64'h5A, 8'hFF, 1'b0);
      w_send(64'hA5, 8'hFF, 1'b1);
      b_get(id, rs);
      chk("wr_decerr_resp", 64'(rs), 64'd3);
      chk("wr_decerr_writes", 64'(wr_cnt - c0), 64'd1);

      // exclusive pair
      ar_send(4'b1011, 64'h200, 8'd0, 2'b01, 1'b1);
      r_get(d, id, rs, l, lat);
`ifdef AXI_SRAM_RESPONDER_EXCL_EN
      chk("lr_resp", 64'(rs), 64'd1);
`else
      chk("lr_resp", 64'(rs), 64'd0);
`endif
      aw_send(4'b1011, 64'h200, 8'd0, 1'b1, 6'd0);
      w_send(64'hAAAA, 8'hFF, 1'b1);
      b_get(id, rs);
`ifdef AXI_SRAM_RESPONDER_EXCL_EN
      chk("sc1_resp", 64'(rs), 64'd1);
`else
      chk("sc1_resp", 64'(rs), 64'd0);
`endif
      chk("sc1_word", sram[14'h40], 64'hAAAA);
      aw_send(4'b1011, 64'h200, 8'd0, 1'b1, 6'd0);
      w_send(64'hBBBB, 8'hFF, 1'b1);
      b_get(id, rs);
      chk("sc2_resp", 64'(rs), 64'd0);
`ifdef AXI_SRAM_RESPONDER_EXCL_EN
      chk("sc2_word", sram[14'h40], 64'hAAAA);
`else
      chk("sc2_word", sram[14'h40], 64'hBBBB);
`endif

      // asynchronous reset in the middle of a write burst
      aw_send(4'd13, 64'h400, 8'd3, 1'b0, 6'd0);
      w_send(64'h1234, 8'hFF, 1'b0);
      @(negedge clk_i);
      #1 rst_ni = 1'b0;
      #1 chk("rst_mid_outputs", 64'({rsp.w_ready, rsp.b_valid, rsp.r_valid, mem_req}), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      ok = 1'b1;
      repeat (4) begin @(negedge clk_i); if (rsp.b_valid || rsp.w_ready) ok = 1'b0; end
      chk("rst_no_response", 64'(ok), 64'd1);
      ar_send(4'd14, 64'h80, 8'd0, 2'b01, 1'b0);
      r_get(d, id, rs, l, lat);
      chk("post_rst_data", d, 64'hDEAD_BEEF_0123_4567);
      chk("post_rst_id", 64'(id), 64'd14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
